// File: rtl/cfg_pkg.sv
// Shared types and constants for the configuration-chain loader.
// Optional readback states are compiled in with CFG_READBACK_EN.
package cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_LOAD,
        ST_CHK,
`ifdef CFG_READBACK_EN
        ST_RDBK,
`endif
        ST_DONE,
        ST_ERR
    } cfg_state_t;

    localparam logic [15:0] CFG_SYNC = 16'hFAB5;

    // Header word layout: {sync, payload length}
    localparam int unsigned HDR_SYNC_HI = 31;
    localparam int unsigned HDR_SYNC_LO = 16;
    localparam int unsigned HDR_LEN_HI  = 15;
    localparam int unsigned HDR_LEN_LO  = 0;

endpackage

// File: rtl/cfg_xor_acc.sv
// Clearable XOR accumulator; clear takes priority over accumulate.
module cfg_xor_acc #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         nres,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge nres) begin
        if (!nres) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= q ^ d;
        end
    end

endmodule

// File: rtl/cfg_loader.sv
// Framed bitstream loader driving the fabric configuration shift chain.
// Define CFG_READBACK_EN to add the recirculating readback/verify pass.
module cfg_loader
    import cfg_pkg::*;
#(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned LEN_W  = 16,
    parameter logic [15:0] SYNC   = CFG_SYNC
) (
    input  logic              clk,
    input  logic              nres,
    input  logic              start,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [WORD_W-1:0] chain_o,
    output logic              chain_shft,
    input  logic [WORD_W-1:0] chain_i,
    output logic              busy,
    output logic              done,
    output logic              err
);

    cfg_state_t        state, next_state;
    logic [LEN_W-1:0]  cnt;
    logic [LEN_W-1:0]  len_q;
    logic [WORD_W-1:0] chain_q;
    logic              shft_q;
    logic [WORD_W-1:0] sum;
    logic              accept;
    logic              idle_like;
    logic              enter_hdr;
    logic              load_word;
    logic              set_done;
    logic              set_err;
    logic [LEN_W-1:0]  hdr_len;

    assign accept    = s_valid & s_ready;
    assign idle_like = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR);
    assign enter_hdr = idle_like & start;
    assign load_word = (state == ST_LOAD) & accept;
    assign hdr_len   = s_data[HDR_LEN_HI:HDR_LEN_LO];
    assign busy      = ~idle_like;

    cfg_xor_acc #(.W(WORD_W)) u_sum (
        .clk  (clk),
        .nres (nres),
        .clr  (enter_hdr),
        .en   (load_word),
        .d    (s_data),
        .q    (sum)
    );

`ifdef CFG_READBACK_EN
    logic [WORD_W-1:0] rsum;
    logic              in_rdbk;

    assign in_rdbk = (state == ST_RDBK);

    cfg_xor_acc #(.W(WORD_W)) u_rsum (
        .clk  (clk),
        .nres (nres),
        .clr  (enter_hdr),
        .en   (in_rdbk),
        .d    (chain_i),
        .q    (rsum)
    );

    // Readback recirculates the chain tail straight back into its head
    assign chain_o    = in_rdbk ? chain_i : chain_q;
    assign chain_shft = shft_q | in_rdbk;
`else
    logic unused_chain_i;

    assign unused_chain_i = ^chain_i;
    assign chain_o        = chain_q;
    assign chain_shft     = shft_q;
`endif

    always_comb begin
        next_state = state;
        set_done   = 1'b0;
        set_err    = 1'b0;
        unique case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) next_state = ST_HDR;
            end
            ST_HDR: begin
                if (accept) begin
                    if (s_data[HDR_SYNC_HI:HDR_SYNC_LO] != SYNC) begin
                        next_state = ST_ERR;
                        set_err    = 1'b1;
                    end else if (hdr_len == '0) begin
                        next_state = ST_CHK;
                    end else begin
                        next_state = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (accept && cnt == LEN_W'(1)) next_state = ST_CHK;
            end
            ST_CHK: begin
                if (accept) begin
                    if (s_data != sum) begin
                        next_state = ST_ERR;
                        set_err    = 1'b1;
`ifdef CFG_READBACK_EN
                    end else if (len_q != '0) begin
                        next_state = ST_RDBK;
`endif
                    end else begin
                        next_state = ST_DONE;
                        set_done   = 1'b1;
                    end
                end
            end
`ifdef CFG_READBACK_EN
            ST_RDBK: begin
                if (cnt == LEN_W'(1)) begin
                    if ((rsum ^ chain_i) == sum) begin
                        next_state = ST_DONE;
                        set_done   = 1'b1;
                    end else begin
                        next_state = ST_ERR;
                        set_err    = 1'b1;
                    end
                end
            end
`endif
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nres) begin
        if (!nres) begin
            state   <= ST_IDLE;
            s_ready <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            cnt     <= '0;
            len_q   <= '0;
            chain_q <= '0;
            shft_q  <= 1'b0;
        end else begin
            state   <= next_state;
            s_ready <= (next_state == ST_HDR) || (next_state == ST_LOAD) ||
                       (next_state == ST_CHK);
            shft_q  <= load_word;
            if (load_word) chain_q <= s_data;

            if (enter_hdr) begin
                done <= 1'b0;
                err  <= 1'b0;
            end else begin
                if (set_done) done <= 1'b1;
                if (set_err)  err  <= 1'b1;
            end

            // cnt counts payload words in LOAD, then readback cycles in RDBK
            if (state == ST_HDR && accept) begin
                cnt   <= hdr_len;
                len_q <= hdr_len;
            end else if (load_word) begin
                cnt <= cnt - LEN_W'(1);
            end else if (state == ST_CHK && accept) begin
                cnt <= len_q;
`ifdef CFG_READBACK_EN
            end else if (in_rdbk) begin
                cnt <= cnt - LEN_W'(1);
`endif
            end
        end
    end

endmodule

// File: doc/cfg_loader.md
# cfg_loader

Bitstream loader that drives the fabric configuration shift chain. It accepts a framed word stream over a valid/ready handshake and checks the header. It then shifts each payload word into the chain with one shift-enable pulse per word, and verifies a trailer checksum. It sits between the host/config port and the `prog_i`/`prog_shft`/`prog_o` chain of the tile array. It is the writing end of that chain.

## Interface
- `WORD_W`, 32, config word width (equals chain `prog_i` width)
- `LEN_W`, 16, payload length field width
- `SYNC`, 16'hFAB5, header sync pattern
- `clk`  in  1  clock
- `nres`  in  1  asynchronous active-low reset
- `start`  in  1  begin a new load; ignored while `busy`
- `s_data`  in  WORD_W  stream word
- `s_valid`  in  1  stream word valid
- `s_ready`  out  1  loader accepts word this cycle
- `chain_o`  out  WORD_W  to first tile `prog_i`
- `chain_shft`  out  1  to all tiles `prog_shft`
- `chain_i`  in  WORD_W  from last tile `prog_o` (readback only)
- `busy`  out  1  high in any state except IDLE/DONE/ERR
- `done`  out  1  sticky success flag
- `err`  out  1  sticky failure flag

## Operation
- States: IDLE, HDR, LOAD, CHK, RDBK (only when readback is compiled in), DONE, ERR.
- IDLE/DONE/ERR + `start` -> HDR. Entering HDR clears `done`, `err` and the checksum accumulator.
- HDR: accepts 1 word.
  - If `s_data[31:16]!=SYNC` -> ERR.
  - Otherwise latch `len=s_data[15:0]`. `len==0` -> CHK; else -> LOAD.
- LOAD: each accepted word is registered onto `chain_o` with `chain_shft=1` the next cycle, and XORed into a 32-bit `sum`.
  - A down-counter decrements per word; the last word goes to CHK.
  - No accepted word means `chain_shft=0` that next cycle (stall, no shift). `chain_o` holds its last value.
- CHK: accepts 1 trailer word.
  - Mismatch with `sum` -> ERR.
  - Match -> DONE, or RDBK if readback is enabled.
- `s_ready` is 1 only in HDR, LOAD and CHK.
- `chain_shft` is never asserted outside LOAD-accepted words and RDBK.
- Reset at any point, including mid-load, returns to IDLE with all outputs 0. The partially shifted chain is left as-is; the host restarts.

## Timing
- Reset values: `s_ready=0`, `chain_o=0`, `chain_shft=0`, `busy=0`, `done=0`, `err=0`.
- `chain_o` and `chain_shft` are registered. A word accepted at edge N shifts into the chain at edge N+1.
- `s_ready` is a registered function of state: high from the cycle after entering HDR.
- Back-to-back acceptance sustains 1 word/cycle: a stream of `len` words occupies exactly `len` shift cycles.
- `done`/`err` rise on the edge the trailer is accepted (or at the end of RDBK). They hold until the next `start`.
- `start` while `busy` is ignored. `start` together with `s_valid` in IDLE: the word is not accepted that cycle.

## Configuration
- `CFG_READBACK_EN` defined: after a CHK match, enter RDBK.
  - For exactly `len` cycles, `chain_shft=1` and `chain_o=chain_i` (combinational mux, no added stage). This recirculates the chain and restores the configuration.
  - XOR `chain_i` on each of those cycles into `rsum`.
  - `rsum==sum` -> DONE; else -> ERR.
  - `s_ready=0` throughout.
- Undefined: RDBK and `chain_i` logic are absent, `chain_i` is unused, and a CHK match goes straight to DONE.

## Structure
- Package `cfg_pkg`:
  - state enum `cfg_state_t`
  - `CFG_SYNC`
  - header field positions (`HDR_SYNC_HI/LO`, `HDR_LEN_HI/LO`)
- One sub-module is natural: `cfg_xor_acc`, a clearable 32-bit XOR accumulator. It is instantiated for `sum`, and for `rsum` under readback.

## Test plan
- Reset mid-LOAD, after 3 of 8 words: all outputs go to 0, state is IDLE, and the next `start` plus a fresh frame reaches DONE.
- Header 32'hFAB5_0004, payload 32'h11111111, 22222222, 44444444, 88888888, trailer 32'hFFFFFFFF, streamed back-to-back: exactly 4 `chain_shft` cycles with those `chain_o` values, then `done=1`, `err=0`.
- Same frame with trailer 32'h00000000: 4 shifts, then `err=1`, `done=0`.
- Header 32'h1234_0004: `err=1` one edge after acceptance, and `chain_shft` never asserts.
- Header 32'hFAB5_0000, trailer 0: `done=1` with no shift cycles.
- Payload with `s_valid` dropped for 2 cycles between words 2 and 3: `chain_shft` is low for those 2 cycles, the total shift count is still 4, and the result is DONE.
- With `CFG_READBACK_EN` and a 4-stage chain model: after CHK, exactly 4 RDBK shifts, chain contents unchanged, `done=1`. With a corrupted model stage: `err=1`.
